// File: rtl/jstk_pkg.sv
// Shared joystick SPI constants: frame length, LED command prefix, FSM states and tx frame packing.
package jstk_pkg;

    localparam int unsigned FRAME_BITS = 40;
    localparam logic [5:0]  CMD_PREFIX = 6'b100000;
    localparam logic [5:0]  FRAME_CNT  = 6'(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        OVERRUN
    } state_t;

    // Byte slots counted from the LSB end of the frame word; slot 4 is sent first.
    localparam int unsigned BYTE_X_LO = 4;
    localparam int unsigned BYTE_X_HI = 3;
    localparam int unsigned BYTE_Y_LO = 2;
    localparam int unsigned BYTE_Y_HI = 1;
    localparam int unsigned BYTE_BTN  = 0;

    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [1:0] btn,
        input logic       jbtn
    );
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[BYTE_X_LO*8 +: 8] = x[7:0];
        f[BYTE_X_HI*8 +: 2] = x[9:8];
        f[BYTE_Y_LO*8 +: 8] = y[7:0];
        f[BYTE_Y_HI*8 +: 2] = y[9:8];
        f[BYTE_BTN*8  +: 3] = {btn, jbtn};
        return f;
    endfunction

endpackage

// File: rtl/jstk_spi_responder_if.sv
// SPI pin bundle between the joystick master and the responder.
interface jstk_spi_responder_if;

    logic sck;
    logic cs;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output sck, output cs, output mosi, input miso, input miso_oe);
    modport slave  (input sck, input cs, input mosi, output miso, output miso_oe);

endinterface

// File: rtl/spi_pin_sync.sv
// SPI pin conditioning and sck/cs edge detection. JSTK_PIN_SYNC_EN selects 2-flop synchronisers
// (3-cycle pin-to-event latency); otherwise a single register for a clk50M-synchronous master.
module spi_pin_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sck,
    input  logic cs,
    input  logic mosi,
    output logic mosi_lvl,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_rise,
    output logic cs_fall
);

`ifdef JSTK_PIN_SYNC_EN
    logic [2:0] sck_sr;
    logic [2:0] cs_sr;
    logic [1:0] mosi_sr;

    // Reset preloads the pin level so a frame already in flight cannot raise a false edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_sr  <= {3{sck}};
            cs_sr   <= {3{cs}};
            mosi_sr <= {2{mosi}};
        end else begin
            sck_sr  <= {sck_sr[1:0], sck};
            cs_sr   <= {cs_sr[1:0], cs};
            mosi_sr <= {mosi_sr[0], mosi};
        end
    end

    assign mosi_lvl = mosi_sr[1];
    assign sck_rise = sck_sr[1] & ~sck_sr[2];
    assign sck_fall = ~sck_sr[1] & sck_sr[2];
    assign cs_rise  = cs_sr[1] & ~cs_sr[2];
    assign cs_fall  = ~cs_sr[1] & cs_sr[2];
`else
    logic sck_q;
    logic cs_q;

    always_ff @(posedge clk) begin
        sck_q <= sck;
        cs_q  <= cs;
    end

    assign mosi_lvl = mosi;
    assign sck_rise = sck & ~sck_q;
    assign sck_fall = ~sck & sck_q;
    assign cs_rise  = cs & ~cs_q;
    assign cs_fall  = ~cs & cs_q;
`endif

endmodule

// File: rtl/jstk_spi_responder.sv
// SPI slave emulating the 2-axis joystick: returns an x/y/button snapshot, captures LED commands.
// Pin synchroniser depth is selected by JSTK_PIN_SYNC_EN (see spi_pin_sync).
module jstk_spi_responder
    import jstk_pkg::*;
(
    input  logic                 clk50M,
    input  logic                 rst_n,
    input  logic [9:0]           x,
    input  logic [9:0]           y,
    input  logic [1:0]           btn,
    input  logic                 jbtn,
    jstk_spi_responder_if.slave  spi,
    output logic [1:0]           led,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic                 busy
);

    logic mosi_lvl, sck_rise, sck_fall, cs_rise, cs_fall;

    spi_pin_sync u_pin_sync (
        .clk      (clk50M),
        .rst_n    (rst_n),
        .sck      (spi.sck),
        .cs       (spi.cs),
        .mosi     (spi.mosi),
        .mosi_lvl (mosi_lvl),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_rise  (cs_rise),
        .cs_fall  (cs_fall)
    );

    state_t                state, state_nxt;
    logic [5:0]            bit_cnt, bit_cnt_nxt;
    logic [FRAME_BITS-1:0] tx_sr, tx_nxt;
    logic [FRAME_BITS-1:0] rx_sr, rx_nxt;
    logic                  miso_r, miso_nxt;
    logic                  oe_r, oe_nxt;
    logic [1:0]            led_r, led_nxt;
    logic                  done_r, done_nxt;
    logic                  err_r, err_nxt;

    always_ff @(posedge clk50M) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            miso_r  <= 1'b0;
            oe_r    <= 1'b0;
            led_r   <= '0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            tx_sr   <= tx_nxt;
            rx_sr   <= rx_nxt;
            miso_r  <= miso_nxt;
            oe_r    <= oe_nxt;
            led_r   <= led_nxt;
            done_r  <= done_nxt;
            err_r   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        tx_nxt      = tx_sr;
        rx_nxt      = rx_sr;
        miso_nxt    = miso_r;
        oe_nxt      = oe_r;
        led_nxt     = led_r;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    tx_nxt      = pack_frame(x, y, btn, jbtn);
                    miso_nxt    = tx_nxt[FRAME_BITS-1];
                    oe_nxt      = 1'b1;
                    bit_cnt_nxt = '0;
                    rx_nxt      = '0;
                    state_nxt   = ACTIVE;
                end
            end
            ACTIVE: begin
                // cs_rise takes priority over any sck edge seen in the same cycle.
                if (cs_rise) begin
                    err_nxt   = 1'b1;
                    miso_nxt  = 1'b0;
                    oe_nxt    = 1'b0;
                    state_nxt = IDLE;
                end else if (sck_rise) begin
                    rx_nxt      = {rx_sr[FRAME_BITS-2:0], mosi_lvl};
                    bit_cnt_nxt = bit_cnt + 6'd1;
                    if (bit_cnt_nxt == FRAME_CNT) begin
                        state_nxt = OVERRUN;
                    end
                end else if (sck_fall) begin
                    tx_nxt   = {tx_sr[FRAME_BITS-2:0], 1'b0};
                    miso_nxt = tx_sr[FRAME_BITS-2];
                end
            end
            OVERRUN: begin
                miso_nxt = 1'b0;
                if (cs_rise) begin
                    done_nxt  = 1'b1;
                    oe_nxt    = 1'b0;
                    state_nxt = IDLE;
                    if (rx_sr[FRAME_BITS-1 -: 6] == CMD_PREFIX) begin
                        led_nxt = rx_sr[FRAME_BITS-7 -: 2];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign spi.miso    = miso_r;
    assign spi.miso_oe = oe_r;
    assign led         = led_r;
    assign frame_done  = done_r;
    assign frame_err   = err_r;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Self-checking bench for jstk_spi_responder: directed table, randomized frames vs a byte-level model,
// mid-frame input change and mid-frame reset sequences.
module tb_jstk_spi_responder;
    import jstk_pkg::*;

    localparam int HALF = 9;

    logic       clk50M = 1'b0;
    logic       rst_n;
    logic [9:0] x, y;
    logic [1:0] btn;
    logic       jbtn;
    logic [1:0] led;
    logic       frame_done, frame_err, busy;

    jstk_spi_responder_if spi_if ();

    jstk_spi_responder dut (
        .clk50M     (clk50M),
        .rst_n      (rst_n),
        .x          (x),
        .y          (y),
        .btn        (btn),
        .jbtn       (jbtn),
        .spi        (spi_if),
        .led        (led),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #10 clk50M = ~clk50M;

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;
    int err_seen = 0;

    // Counts high cycles, so a stretched pulse shows up as an extra count.
    always @(negedge clk50M) begin
        if (frame_done) done_seen++;
        if (frame_err)  err_seen++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: five bytes assembled arithmetically, sent MSB first; anything past 40 bits is zero.
    function automatic logic [47:0] model_miso(input logic [9:0] mx, input logic [9:0] my,
                                               input logic [1:0] mb, input logic mj);
        int unsigned b[5];
        logic [47:0] r;
        b[0] = mx % 256;
        b[1] = mx / 256;
        b[2] = my % 256;
        b[3] = my / 256;
        b[4] = mb * 2 + mj;
        r = '0;
        for (int i = 0; i < 40; i++) r[47-i] = ((b[i/8] >> (7 - i % 8)) & 1) != 0;
        return r;
    endfunction

    logic [1:0] m_led;

    function automatic logic [1:0] model_led(input logic [1:0] cur, input int nbits, input logic [7:0] b0);
        if (nbits >= 40 && (b0 >> 2) == 32) return 2'(b0 % 4);
        return cur;
    endfunction

    task automatic run_frame(input logic [9:0] fx, input logic [9:0] fy, input logic [1:0] fb,
                             input logic fj, input int nbits, input logic [47:0] mosi_w,
                             input int chg_bit, input logic [9:0] chg_x, input int rst_bit,
                             output logic [47:0] miso_w);
        @(negedge clk50M);
        x = fx; y = fy; btn = fb; jbtn = fj;
        spi_if.cs = 1'b0;
        repeat (10) @(negedge clk50M);
        miso_w = '0;
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_bit) x = chg_x;
            if (i == rst_bit) begin
                rst_n = 1'b0;
                repeat (2) @(negedge clk50M);
                check("rst_mid_miso", spi_if.miso, 0);
                check("rst_mid_oe", spi_if.miso_oe, 0);
                check("rst_mid_led", led, 0);
                check("rst_mid_busy", busy, 0);
                rst_n = 1'b1;
            end
            spi_if.mosi = mosi_w[47-i];
            repeat (HALF) @(negedge clk50M);
            spi_if.sck = 1'b1;
            miso_w[47-i] = spi_if.miso;
            if (i == nbits / 2 && rst_bit < 0) begin
                check("busy_mid", busy, 1);
                check("oe_mid", spi_if.miso_oe, 1);
            end
            repeat (HALF) @(negedge clk50M);
            spi_if.sck = 1'b0;
        end
        repeat (HALF) @(negedge clk50M);
        spi_if.cs = 1'b1;
        repeat (10) @(negedge clk50M);
    endtask

    typedef struct {
        logic [9:0]  x, y;
        logic [1:0]  btn;
        logic        jbtn;
        int          nbits;
        logic [7:0]  b0;
        logic [47:0] exp_miso;
        logic [1:0]  exp_led;
        int          exp_done;
        int          exp_err;
    } vec_t;

    vec_t tbl[5];

    task automatic check_end(input int nbits, input logic [47:0] got, input logic [47:0] exp,
                             input logic [1:0] exp_led, input int d0, input int e0,
                             input int exp_done, input int exp_err);
        logic [47:0] mask;
        mask = ~({48{1'b1}} >> nbits);
        check("miso_bits", got & mask, exp & mask);
        check("led", led, exp_led);
        check("done_pulses", done_seen - d0, exp_done);
        check("err_pulses", err_seen - e0, exp_err);
        check("oe_after", spi_if.miso_oe, 0);
        check("miso_after", spi_if.miso, 0);
        check("busy_after", busy, 0);
    endtask

    initial begin
        logic [47:0] got, exp, mw;
        logic [9:0]  rx, ry;
        logic [1:0]  rb;
        logic        rj;
        logic [7:0]  b0;
        int          nb, d0, e0;

        tbl[0] = '{10'h2A5, 10'h17F, 2'b10, 1'b1, 40, 8'h83, {40'hA5_02_7F_01_05, 8'h00}, 2'b11, 1, 0};
        tbl[1] = '{10'h2A5, 10'h17F, 2'b10, 1'b1, 40, 8'h41, {40'hA5_02_7F_01_05, 8'h00}, 2'b11, 1, 0};
        tbl[2] = '{10'h3FF, 10'h000, 2'b01, 1'b0, 17, 8'h81, {40'hFF_03_00_00_02, 8'h00}, 2'b11, 0, 1};
        tbl[3] = '{10'h155, 10'h2AA, 2'b11, 1'b0, 40, 8'h82, {40'h55_01_AA_02_06, 8'h00}, 2'b10, 1, 0};
        tbl[4] = '{10'h001, 10'h3FE, 2'b00, 1'b1, 48, 8'h80, {40'h01_00_FE_03_01, 8'h00}, 2'b00, 1, 0};

        spi_if.cs = 1'b1; spi_if.sck = 1'b0; spi_if.mosi = 1'b0;
        x = '0; y = '0; btn = '0; jbtn = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk50M);
        check("rst_miso", spi_if.miso, 0);
        check("rst_oe", spi_if.miso_oe, 0);
        check("rst_led", led, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", frame_err, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk50M);
        m_led = 2'b00;

        for (int k = 0; k < 5; k++) begin
            d0 = done_seen; e0 = err_seen;
            run_frame(tbl[k].x, tbl[k].y, tbl[k].btn, tbl[k].jbtn, tbl[k].nbits,
                      {tbl[k].b0, 40'h0}, -1, 10'h0, -1, got);
            check_end(tbl[k].nbits, got, tbl[k].exp_miso, tbl[k].exp_led, d0, e0,
                      tbl[k].exp_done, tbl[k].exp_err);
            m_led = tbl[k].exp_led;
        end

        for (int k = 0; k < 16; k++) begin
            rx = 10'($urandom); ry = 10'($urandom); rb = 2'($urandom); rj = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       nb = $urandom_range(0, 39);
                3:       nb = $urandom_range(41, 48);
                default: nb = 40;
            endcase
            b0 = ($urandom_range(0, 1) != 0) ? {6'b100000, 2'($urandom)} : 8'($urandom);
            mw = {b0, 32'($urandom), 8'($urandom)};
            d0 = done_seen; e0 = err_seen;
            run_frame(rx, ry, rb, rj, nb, mw, -1, 10'h0, -1, got);
            m_led = model_led(m_led, nb, b0);
            check_end(nb, got, model_miso(rx, ry, rb, rj), m_led, d0, e0,
                      (nb >= 40) ? 1 : 0, (nb < 40) ? 1 : 0);
        end

        // x changes after byte0: the whole frame must still carry the cs_fall snapshot.
        rx = 10'h2C3; ry = 10'h0F0; rb = 2'b01; rj = 1'b1;
        d0 = done_seen; e0 = err_seen;
        run_frame(rx, ry, rb, rj, 40, {8'h82, 40'h0}, 8, rx ^ 10'h3FF, -1, got);
        m_led = 2'b10;
        check_end(40, got, model_miso(rx, ry, rb, rj), m_led, d0, e0, 1, 0);

        // Reset at bit 20 with cs held low: no pulses, LED back to 0.
        d0 = done_seen; e0 = err_seen;
        run_frame(10'h111, 10'h222, 2'b11, 1'b1, 40, {8'h83, 40'h0}, -1, 10'h0, 20, got);
        m_led = 2'b00;
        check("rst_frame_done", done_seen - d0, 0);
        check("rst_frame_err", err_seen - e0, 0);
        check("rst_frame_led", led, m_led);
        check("rst_frame_busy", busy, 0);

        rx = 10'h3A7; ry = 10'h15C; rb = 2'b10; rj = 1'b0;
        d0 = done_seen; e0 = err_seen;
        run_frame(rx, ry, rb, rj, 40, {8'h81, 40'h0}, -1, 10'h0, -1, got);
        m_led = 2'b01;
        check_end(40, got, model_miso(rx, ry, rb, rj), m_led, d0, e0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
